// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter.
package dmem_arbiter_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DMA  = 2'd2
  } owner_e;

  localparam int unsigned STARVE_LIMIT_DEFAULT = 8;

endpackage

// File: rtl/dmem_starve_counter.sv
// Saturating DMA wait counter; clear has priority over increment.
module dmem_starve_counter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned limit = STARVE_LIMIT_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       inc,
  input  logic       clr,
  output logic [7:0] cnt
);

  localparam logic [7:0] LIMIT8 = 8'(limit);

  logic [7:0] r_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (inc && (r_cnt != LIMIT8)) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  assign cnt = r_cnt;

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester data-memory arbiter: CPU priority with DMA starvation guard,
// one-cycle read return routed to the requester that issued the read.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_stall,
  output logic        cpu_rvalid,
  output logic [31:0] cpu_rdata,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  output logic        dma_gnt,
  output logic        dma_rvalid,
  output logic [31:0] dma_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic [1:0]  owner
);

  localparam logic [7:0] LIMIT8 = 8'(STARVE_LIMIT);

  owner_e     w_owner;
  owner_e     r_rd_owner;
  logic [7:0] w_starve_cnt;
  logic       w_dma_win;

  always_comb begin
    w_owner = OWN_NONE;
    if (dma_req && (w_starve_cnt == LIMIT8)) begin
      w_owner = OWN_DMA;
    end else if (cpu_req) begin
      w_owner = OWN_CPU;
    end else if (dma_req) begin
      w_owner = OWN_DMA;
    end
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (w_owner)
      OWN_CPU: begin
        mem_en    = 1'b1;
        mem_we    = cpu_we;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
      end
      OWN_DMA: begin
        mem_en    = 1'b1;
        mem_we    = dma_we;
        mem_addr  = dma_addr;
        mem_wdata = dma_wdata;
      end
      default: ;
    endcase
  end

  assign w_dma_win = (w_owner == OWN_DMA);
  assign owner     = w_owner;
  // Grant and stall are the only combinational outputs silenced in reset.
  assign dma_gnt   = reset && w_dma_win;
  assign cpu_stall = reset && cpu_req && (w_owner != OWN_CPU);

  dmem_starve_counter #(
    .limit(STARVE_LIMIT)
  ) u_starve (
    .clk  (clk),
    .reset(reset),
    .inc  (dma_req && !w_dma_win),
    .clr  (!dma_req || w_dma_win),
    .cnt  (w_starve_cnt)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd_owner <= OWN_NONE;
    end else if (mem_en && !mem_we) begin
      r_rd_owner <= w_owner;
    end else begin
      r_rd_owner <= OWN_NONE;
    end
  end

  assign cpu_rvalid = (r_rd_owner == OWN_CPU);
  assign dma_rvalid = (r_rd_owner == OWN_DMA);
  assign cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
  assign dma_rdata  = dma_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

  localparam int LIMIT = 8;

  logic        clk;
  logic        reset;
  logic        cpu_req, cpu_we, dma_req, dma_we;
  logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
  logic        cpu_stall, cpu_rvalid, dma_gnt, dma_rvalid;
  logic [31:0] cpu_rdata, dma_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  owner;

  dmem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .owner(owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous data memory behind the arbiter.
  logic [31:0] ram [16];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr[5:2]] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr[5:2]];
    end
  end

  int checks;
  int failures;

  task automatic check32(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", tag, act, exp);
    end
  endtask

  // Reference model: rule-level grant, wait count, memory image, return queue.
  typedef struct { int own; logic [31:0] data; } ret_t;
  ret_t        rq[$];
  int          m_wait;
  logic [31:0] m_mem [16];

  task automatic cycle(input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
                       input logic dr, input logic dw, input logic [31:0] da, input logic [31:0] dd,
                       output int g, output logic [31:0] crd);
    logic        ew;
    logic [31:0] ea, ed;
    ret_t        r;
    ret_t        nr;
    cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    dma_req = dr; dma_we = dw; dma_addr = da; dma_wdata = dd;
    g = 0;
    if (dr && m_wait >= LIMIT) g = 2;
    else if (cr)               g = 1;
    else if (dr)               g = 2;
    ew = 1'b0; ea = '0; ed = '0;
    if (g == 1) begin ew = cw; ea = ca; ed = cd; end
    if (g == 2) begin ew = dw; ea = da; ed = dd; end
    if (rq.size() > 0) r = rq.pop_front();
    else begin r.own = 0; r.data = '0; end
    @(negedge clk);
    check32("owner",      32'(owner),      32'(g));
    check32("mem_en",     32'(mem_en),     32'(g != 0));
    check32("mem_we",     32'(mem_we),     32'(ew));
    check32("mem_addr",   mem_addr,        ea);
    check32("mem_wdata",  mem_wdata,       ed);
    check32("dma_gnt",    32'(dma_gnt),    32'(g == 2));
    check32("cpu_stall",  32'(cpu_stall),  32'(cr && g != 1));
    check32("cpu_rvalid", 32'(cpu_rvalid), 32'(r.own == 1));
    check32("dma_rvalid", 32'(dma_rvalid), 32'(r.own == 2));
    check32("cpu_rdata",  cpu_rdata,       (r.own == 1) ? r.data : 32'h0);
    check32("dma_rdata",  dma_rdata,       (r.own == 2) ? r.data : 32'h0);
    crd = cpu_rdata;
    nr.own = 0; nr.data = '0;
    if (g != 0) begin
      if (ew) m_mem[ea[5:2]] = ed;
      else begin nr.own = g; nr.data = m_mem[ea[5:2]]; end
    end
    rq.push_back(nr);
    if (dr && g != 2) m_wait = (m_wait + 1 > LIMIT) ? LIMIT : m_wait + 1;
    else              m_wait = 0;
    @(posedge clk); #1;
  endtask

  initial begin
    int          g;
    int          first_dma, second_dma;
    logic [31:0] crd;
    logic        pend;
    logic        p_we;
    logic [31:0] p_addr, p_data;
    checks = 0; failures = 0;
    m_wait = 0;
    for (int unsigned i = 0; i < 16; i++) begin
      ram[i]   = $urandom;
      m_mem[i] = ram[i];
    end
    reset = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0; cpu_wdata = '0;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h4; dma_wdata = '0;

    // Reset: registered returns cleared, grant/stall forced low, owner follows.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check32("rst_cpu_rvalid", 32'(cpu_rvalid), 32'h0);
    check32("rst_dma_rvalid", 32'(dma_rvalid), 32'h0);
    check32("rst_cpu_rdata",  cpu_rdata,       32'h0);
    check32("rst_dma_rdata",  dma_rdata,       32'h0);
    check32("rst_dma_gnt",    32'(dma_gnt),    32'h0);
    check32("rst_cpu_stall",  32'(cpu_stall),  32'h0);
    check32("rst_owner",      32'(owner),      32'h1);
    cpu_req = 1'b0; dma_req = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;

    // CPU read of 0x10 alone, then idle to observe the return.
    cycle(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, g, crd);
    cycle(1'b0, 1'b0, 32'h0,  32'h0, 1'b0, 1'b0, 32'h0, 32'h0, g, crd);

    // Both requesting continuously: DMA forced in on the 9th cycle and again 9 later.
    first_dma = -1; second_dma = -1;
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 1'b0, 32'(i * 4), 32'h0, 1'b1, 1'b0, 32'h3C, 32'h0, g, crd);
      if (g == 2 && first_dma < 0)                       first_dma = i;
      else if (g == 2 && second_dma < 0)                 second_dma = i;
    end
    check32("starve_first_dma",  32'(first_dma),  32'd8);
    check32("starve_second_dma", 32'(second_dma), 32'd17);
    cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, g, crd);

    // DMA write then CPU read of the same word, strictly in grant order.
    cycle(1'b0, 1'b0, 32'h0,  32'h0, 1'b1, 1'b1, 32'h20, 32'hDEADBEEF, g, crd);
    cycle(1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 1'b0, 32'h0,  32'h0,        g, crd);
    cycle(1'b0, 1'b0, 32'h0,  32'h0, 1'b0, 1'b0, 32'h0,  32'h0,        g, crd);
    check32("raw_cpu_rdata", crd, 32'hDEADBEEF);

    // Alternating CPU/DMA reads every cycle.
    for (int i = 0; i < 10; i++) begin
      if (i % 2 == 0) cycle(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, g, crd);
      else            cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h4, 32'h0, g, crd);
    end
    cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, g, crd);

    // DMA read granted, reset asserted before the next edge: return discarded.
    cpu_req = 1'b0; dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h8;
    @(negedge clk);
    check32("inflight_dma_gnt", 32'(dma_gnt), 32'h1);
    reset = 1'b0;
    #1;
    check32("inflight_rst_gnt", 32'(dma_gnt), 32'h0);
    dma_req = 1'b0;
    @(posedge clk); #1;
    check32("inflight_rst_rvalid", 32'(dma_rvalid), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    rq.delete();
    m_wait = 0;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++)
      cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, g, crd);

    // Random traffic; DMA request held until granted.
    pend = 1'b0; p_we = 1'b0; p_addr = '0; p_data = '0;
    for (int i = 0; i < 400; i++) begin
      if (!pend && ($urandom % 3 == 0)) begin
        pend   = 1'b1;
        p_we   = 1'($urandom_range(0, 1));
        p_addr = $urandom & 32'hFFFF_FFFC;
        p_data = $urandom;
      end
      cycle(($urandom % 5) != 0, 1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC, $urandom,
            pend, p_we, p_addr, p_data, g, crd);
      if (g == 2) pend = 1'b0;
    end
    cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, g, crd);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 8, legal range 1..255: DMA wait cycles before the DMA requester is forced onto the bus.
REQ-002 clk  input  1  single system clock; all state changes on the rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 cpu_req  input  1  MEM-stage access request (MemRead or MemWrite).
REQ-005 cpu_we  input  1  1 = write, 0 = read.
REQ-006 cpu_addr  input  32  byte address from the ALU result.
REQ-007 cpu_wdata  input  32  store data.
REQ-008 cpu_stall  output  1  CPU request was refused this cycle; the hazard unit freezes PC, IF/ID, ID/EX and EX/MEM.
REQ-009 cpu_rvalid  output  1  cpu_rdata is valid this cycle.
REQ-010 cpu_rdata  output  32  read return to the MEM/WB mux.
REQ-011 dma_req  input  1  UART loader/DMA request, held until granted.
REQ-012 dma_we  input  1  1 = write, 0 = read.
REQ-013 dma_addr  input  32  byte address.
REQ-014 dma_wdata  input  32  write data.
REQ-015 dma_gnt  output  1  DMA access issued this cycle.
REQ-016 dma_rvalid  output  1  dma_rdata is valid this cycle.
REQ-017 dma_rdata  output  32  read return.
REQ-018 mem_en  output  1  data memory access strobe.
REQ-019 mem_we  output  1  data memory write enable.
REQ-020 mem_addr  output  32  data memory address.
REQ-021 mem_wdata  output  32  data memory write data.
REQ-022 mem_rdata  input  32  data memory synchronous read data, valid one cycle after mem_en with mem_we = 0.
REQ-023 owner  output  2  current grant: 0 = none, 1 = CPU, 2 = DMA.

Function
REQ-024 Grant shall be combinational from cpu_req, dma_req and the registered starve_cnt; at most one requester is granted per cycle.
REQ-025 Normal priority: cpu_req = 1 grants the CPU; otherwise dma_req = 1 grants the DMA; otherwise owner = 0 and mem_en = 0.
REQ-026 starve_cnt (8 bit) shall increment each cycle dma_req = 1 and dma_gnt = 0, saturate at STARVE_LIMIT, and clear on any DMA grant or when dma_req = 0.
REQ-027 When starve_cnt == STARVE_LIMIT and dma_req = 1, the DMA shall be granted regardless of cpu_req; if cpu_req = 1, cpu_stall = 1 for that cycle.
REQ-028 cpu_stall shall be 0 whenever cpu_req = 0 or the CPU is granted.
REQ-029 mem_en, mem_we, mem_addr and mem_wdata shall mux combinationally from the granted requester; mem_addr and mem_wdata shall be 0 when owner = 0.
REQ-030 Read latency: a granted read (we = 0) in cycle N shall give the owner's rvalid = 1 in cycle N+1, with rdata = mem_rdata.
REQ-031 The read owner shall be captured in a registered rd_owner; the other requester's rvalid stays 0 and its rdata holds 0.
REQ-032 Writes shall complete in the grant cycle and produce no rvalid.
REQ-033 Back-to-back reads from alternating owners shall each return in order with one-cycle latency, with no bubble.
REQ-034 A DMA write and CPU read of the same address in consecutive cycles shall be serialized strictly in grant order; no forwarding is performed.

Reset
REQ-035 While reset = 0: starve_cnt = 0, rd_owner = none, cpu_rvalid = dma_rvalid = 0, cpu_rdata = dma_rdata = 0.
REQ-036 A read in flight when reset asserts shall be discarded; no rvalid shall appear after reset deasserts.
REQ-037 Combinational outputs shall follow their inputs during reset, except dma_gnt = 0 and cpu_stall = 0.

Structure
REQ-038 The shared package shall hold the owner encodings (OWN_NONE = 0, OWN_CPU = 1, OWN_DMA = 2) and the STARVE_LIMIT default.
REQ-039 The saturating wait counter shall be one sub-module, dmem_starve_counter (inputs inc, clr; output cnt; parameter limit).

Verification
REQ-040 CPU read of addr 0x10 alone -> mem_en = 1 and owner = 1 in cycle N; cpu_rvalid = 1 and cpu_rdata = mem_rdata in N+1.
REQ-041 cpu_req and dma_req both held high, STARVE_LIMIT = 8 -> CPU granted for 8 cycles; DMA granted in the 9th with cpu_stall = 1; starve_cnt = 0 afterwards.
REQ-042 DMA write 0xDEADBEEF to 0x20, then CPU read of 0x20 -> mem_we = 1 in cycle N; in cycle N+2 cpu_rdata = 0xDEADBEEF and dma_rvalid stays 0.
REQ-043 Alternating CPU/DMA reads to 0x0 and 0x4 every cycle -> rvalid alternates CPU/DMA each cycle with matching data; no stalls.
REQ-044 DMA read granted, reset asserted before the next edge -> no rvalid in any cycle; all registered outputs 0 after reset releases.
